if_id_stage: RTL and testbench

//  Fetch-side stage directly downstream of the program counter.
//  - Pairs each PC value with the word returned by the synchronous instruction memory.
//  - Holds that word across hazard stalls and squashes it on branch/jump flush.
//  - Presents a registered IF/ID bundle (instr, pc, pc+1, valid) to decode.
//  - PC is word-addressed: sequential PC step is +1.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/if_id_hold_buf.sv | 34 +++
 rtl/if_id_stage.sv | 84 ++++++++
 tb/tb_if_id_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: opcode constants, default NOP word and the IF/ID bundle type.
package fetch_pkg;

  localparam logic [5:0]  OP_J          = 6'b000010;
  localparam logic [5:0]  OP_JAL        = 6'b000011;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        valid;
  } if_id_t;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/if_id_hold_buf.sv
// Captures the imem word that arrives during the first stall cycle and replays it on release,
// since the memory returns the word for the held PC afterwards.
module if_id_hold_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] sel_instr
);

  logic [DATA_W-1:0] hold_q;
  logic              hold_vld_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hold_vld_q <= 1'b0;
    end else if (stall) begin
      if (!hold_vld_q) begin
        hold_q     <= imem_rdata;
        hold_vld_q <= 1'b1;
      end
    end else begin
      hold_vld_q <= 1'b0;
    end
  end

  assign sel_instr = hold_vld_q ? hold_q : imem_rdata;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: pairs PC with synchronous imem data, handles stall/flush.
// Optional jump predecode is enabled by defining IF_ID_PREDECODE_EN.
module if_id_stage
  import fetch_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              pd_is_jump,
  output logic [ADDR_W-1:0] pd_jump_address
);

  logic [ADDR_W-1:0] fetch_pc_q;
  logic              fetch_vld_q;
  logic [DATA_W-1:0] sel_instr;
  logic [DATA_W-1:0] load_instr;
  logic [ADDR_W-1:0] fetch_pc_plus1;

  if_id_hold_buf #(.DATA_W(DATA_W)) u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .imem_rdata (imem_rdata),
    .sel_instr  (sel_instr)
  );

  assign fetch_pc_plus1 = fetch_pc_q + ADDR_W'(1);
  assign load_instr     = fetch_vld_q ? sel_instr : NOP_INSTR;

  // F slot -> D slot boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q     <= '0;
      fetch_vld_q    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (flush) begin
      // Redirected PC still enters F, but as a bubble; the target arrives on the next fetch.
      fetch_pc_q     <= pc_in;
      fetch_vld_q    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= fetch_pc_q;
      if_id_pc_plus1 <= fetch_pc_plus1;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      fetch_pc_q     <= pc_in;
      fetch_vld_q    <= 1'b1;
      if_id_instr    <= load_instr;
      if_id_pc       <= fetch_pc_q;
      if_id_pc_plus1 <= fetch_pc_plus1;
      if_id_valid    <= fetch_vld_q;
    end
  end

`ifdef IF_ID_PREDECODE_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pd_is_jump      <= 1'b0;
      pd_jump_address <= '0;
    end else if (!stall) begin
      pd_is_jump      <= fetch_vld_q & is_jump_op(load_instr[DATA_W-1:DATA_W-6]);
      pd_jump_address <= {fetch_pc_plus1[ADDR_W-1:26], load_instr[25:0]};
    end
  end
`else
  assign pd_is_jump      = 1'b0;
  assign pd_jump_address = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage with a word-addressed PC and synchronous imem model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] pc, redirect, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus1, pd_jump_address;
  logic        if_id_valid, pd_is_jump;
  logic [96:0] obs;
  int          checks = 0;
  int          errors = 0;

`ifdef IF_ID_PREDECODE_EN
  localparam logic        EXP_PD_J = 1'b1;
  localparam logic [31:0] EXP_PD_A = 32'h0000_0123;
`else
  localparam logic        EXP_PD_J = 1'b0;
  localparam logic [31:0] EXP_PD_A = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .flush           (flush),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus1  (if_id_pc_plus1),
    .if_id_valid     (if_id_valid),
    .pd_is_jump      (pd_is_jump),
    .pd_jump_address (pd_jump_address)
  );

  assign obs = {if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus1};

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0800_0123;
    return 32'hA000_0000 | a;
  endfunction

  // PC register and synchronous instruction memory around the stage
  always @(posedge clk) begin
    if (reset)       pc <= 32'h0;
    else if (flush)  pc <= redirect;
    else if (!stall) pc <= pc + 32'h1;
    imem_rdata <= word(pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [96:0] e;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 32'h0;
    repeat (3) tick();
    e = {1'b0, 32'h0, 32'h0, 32'h0};
    checks++; if (obs !== e) begin errors++; $display("FAIL reset_state got %h exp %h", obs, e); end
    checks++; if ({pd_is_jump, pd_jump_address} !== 33'h0) begin errors++; $display("FAIL reset_pd got %b %h exp 0 0", pd_is_jump, pd_jump_address); end
    reset = 1'b0;
    tick();
    e = {1'b0, 32'h0, 32'h0, 32'h1};
    checks++; if (obs !== e) begin errors++; $display("FAIL rel_edge1 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h0, 32'hA000_0000, 32'h1};
    checks++; if (obs !== e) begin errors++; $display("FAIL rel_pc0 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h1, 32'hA000_0001, 32'h2};
    checks++; if (obs !== e) begin errors++; $display("FAIL rel_pc1 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h2, 32'hA000_0002, 32'h3};
    checks++; if (obs !== e) begin errors++; $display("FAIL rel_pc2 got %h exp %h", obs, e); end
  endtask

  task automatic test_stall();
    logic [96:0] e;
    tick(); tick();
    e = {1'b1, 32'h4, 32'hA000_0004, 32'h5};
    checks++; if (obs !== e) begin errors++; $display("FAIL pre_stall got %h exp %h", obs, e); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs !== e) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, obs, e); end
    end
    stall = 1'b0;
    tick();
    e = {1'b1, 32'h5, 32'hA000_0005, 32'h6};
    checks++; if (obs !== e) begin errors++; $display("FAIL stall_release got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h6, 32'hA000_0006, 32'h7};
    checks++; if (obs !== e) begin errors++; $display("FAIL stall_next got %h exp %h", obs, e); end
  endtask

  task automatic test_flush();
    logic [96:0] e;
    flush = 1'b1; redirect = 32'h40;
    tick();
    e = {1'b0, 32'h7, 32'h0, 32'h8};
    checks++; if (obs !== e) begin errors++; $display("FAIL flush_d1 got %h exp %h", obs, e); end
    flush = 1'b0;
    tick();
    e = {1'b0, 32'h8, 32'h0, 32'h9};
    checks++; if (obs !== e) begin errors++; $display("FAIL flush_d2 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h40, 32'hA000_0040, 32'h41};
    checks++; if (obs !== e) begin errors++; $display("FAIL flush_target got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h41, 32'hA000_0041, 32'h42};
    checks++; if (obs !== e) begin errors++; $display("FAIL flush_target1 got %h exp %h", obs, e); end
  endtask

  task automatic test_flush_stall();
    logic [96:0] e;
    stall = 1'b1;
    tick();
    e = {1'b1, 32'h41, 32'hA000_0041, 32'h42};
    checks++; if (obs !== e) begin errors++; $display("FAIL fs_stall got %h exp %h", obs, e); end
    flush = 1'b1; redirect = 32'h80;
    tick();
    e = {1'b0, 32'h42, 32'h0, 32'h43};
    checks++; if (obs !== e) begin errors++; $display("FAIL fs_flush_wins got %h exp %h", obs, e); end
    stall = 1'b0; flush = 1'b0;
    tick();
    e = {1'b0, 32'h43, 32'h0, 32'h44};
    checks++; if (obs !== e) begin errors++; $display("FAIL fs_bubble got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h80, 32'hA000_0080, 32'h81};
    checks++; if (obs !== e) begin errors++; $display("FAIL fs_no_stale got %h exp %h", obs, e); end
  endtask

  task automatic test_reset_mid_stall();
    logic [96:0] e;
    stall = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    e = {1'b0, 32'h0, 32'h0, 32'h0};
    checks++; if (obs !== e) begin errors++; $display("FAIL rms_reset got %h exp %h", obs, e); end
    stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    e = {1'b0, 32'h0, 32'h0, 32'h1};
    checks++; if (obs !== e) begin errors++; $display("FAIL rms_edge1 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h0, 32'hA000_0000, 32'h1};
    checks++; if (obs !== e) begin errors++; $display("FAIL rms_pc0 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h1, 32'hA000_0001, 32'h2};
    checks++; if (obs !== e) begin errors++; $display("FAIL rms_pc1 got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h2, 32'hA000_0002, 32'h3};
    checks++; if (obs !== e) begin errors++; $display("FAIL rms_pc2 got %h exp %h", obs, e); end
  endtask

  task automatic test_wrap();
    logic [96:0] e;
    flush = 1'b1; redirect = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0;
    tick(); tick();
    e = {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    checks++; if (obs !== e) begin errors++; $display("FAIL wrap_max got %h exp %h", obs, e); end
    tick();
    e = {1'b1, 32'h0, 32'hA000_0000, 32'h1};
    checks++; if (obs !== e) begin errors++; $display("FAIL wrap_zero got %h exp %h", obs, e); end
  endtask

  task automatic test_predecode();
    logic [96:0] e;
    flush = 1'b1; redirect = 32'h10;
    tick();
    flush = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    e = {1'b0, 32'h10, 32'h0, 32'h11};
    checks++; if (obs !== e) begin errors++; $display("FAIL pd_flushed_d got %h exp %h", obs, e); end
    checks++; if ({pd_is_jump, pd_jump_address} !== 33'h0) begin errors++; $display("FAIL pd_flushed got %b %h exp 0 0", pd_is_jump, pd_jump_address); end
    flush = 1'b0;
    tick(); tick();
    e = {1'b1, 32'h10, 32'h0800_0123, 32'h11};
    checks++; if (obs !== e) begin errors++; $display("FAIL pd_jump_d got %h exp %h", obs, e); end
    checks++; if ({pd_is_jump, pd_jump_address} !== {EXP_PD_J, EXP_PD_A}) begin errors++; $display("FAIL pd_jump got %b %h exp %b %h", pd_is_jump, pd_jump_address, EXP_PD_J, EXP_PD_A); end
    stall = 1'b1;
    tick();
    checks++; if ({pd_is_jump, pd_jump_address} !== {EXP_PD_J, EXP_PD_A}) begin errors++; $display("FAIL pd_stall_hold got %b %h exp %b %h", pd_is_jump, pd_jump_address, EXP_PD_J, EXP_PD_A); end
    stall = 1'b0;
    tick();
    e = {1'b1, 32'h11, 32'hA000_0011, 32'h12};
    checks++; if (obs !== e) begin errors++; $display("FAIL pd_after got %h exp %h", obs, e); end
    checks++; if (pd_is_jump !== 1'b0) begin errors++; $display("FAIL pd_nonjump got %b exp 0", pd_is_jump); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid_stall();
    test_wrap();
    test_predecode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
